regfile_mp_sb: RTL and testbench

Parametrised multi-port integer register file for the RISCV64 core. It succeeds the single-write, two-read register file with configurable read and write port counts and optional same-cycle write-to-read bypass. It adds a per-register busy scoreboard with an issue handshake, and a snapshot of the three accelerator configuration registers (buffer base, load amount, DMEM base) that is captured on request and flagged stale on later writes.

---
 rtl/regfile_mp_sb_pkg.sv | 15 +
 rtl/regfile_mp_sb_if.sv | 36 +++
 rtl/regfile_mp_sb_scoreboard.sv | 53 +++++
 rtl/regfile_mp_sb.sv | 106 ++++++++++
 tb/tb_regfile_mp_sb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults, config-register layout and packed-bus slice helpers for the
// multi-port register file with scoreboard and config snapshot.
`ifndef RF_SLICE
`define RF_SLICE(bus_, k_, w_) bus_[(k_)*(w_) +: (w_)]
`endif

package regfile_mp_sb_pkg;
   localparam int DATA_BITS_DEF = 64;
   localparam int ADDR_BITS_DEF = 5;
   localparam int CFG_BASE_DEF  = 29;
   localparam int CFG_OFS_BBA   = 0;
   localparam int CFG_OFS_BLA   = 1;
   localparam int CFG_OFS_DMB   = 2;
   localparam int CFG_NUM       = 3;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for regfile_mp_sb: read/write ports, issue handshake, config snapshot.
interface regfile_mp_sb_if #(
   parameter int DATA_BITS = 64,
   parameter int ADDR_BITS = 5,
   parameter int NRD       = 2,
   parameter int NWR       = 2
);
   logic [NRD*ADDR_BITS-1:0] rd_addr;
   logic [NRD*DATA_BITS-1:0] rd_data;
   logic [NRD-1:0]           rd_busy;
   logic [NWR-1:0]           wr_en;
   logic [NWR*ADDR_BITS-1:0] wr_addr;
   logic [NWR*DATA_BITS-1:0] wr_data;
   logic                     iss_en;
   logic [ADDR_BITS-1:0]     iss_addr;
   logic                     iss_rdy;
   logic                     iss_err;
   logic [2**ADDR_BITS-1:0]  busy_vec;
   logic                     cfg_snap;
   logic                     cfg_valid;
   logic                     cfg_stale;
   logic [DATA_BITS-1:0]     Buffer_Base_Address;
   logic [DATA_BITS-1:0]     Buffer_Load_Amount;
   logic [DATA_BITS-1:0]     DMEM_Base_Address;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, cfg_snap,
      input  rd_data, rd_busy, iss_rdy, iss_err, busy_vec, cfg_valid, cfg_stale,
             Buffer_Base_Address, Buffer_Load_Amount, DMEM_Base_Address
   );
   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, cfg_snap,
      output rd_data, rd_busy, iss_rdy, iss_err, busy_vec, cfg_valid, cfg_stale,
             Buffer_Base_Address, Buffer_Load_Amount, DMEM_Base_Address
   );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy tracking with issue handshake; a same-cycle write frees the
// destination, and a set beats a clear on the same register.
module regfile_scoreboard
   import regfile_mp_sb_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int NWR       = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NWR-1:0]           wr_en,
   input  logic [NWR*ADDR_BITS-1:0] wr_addr,
   input  logic                     iss_en,
   input  logic [ADDR_BITS-1:0]     iss_addr,
   output logic                     iss_rdy,
   output logic                     iss_err,
   output logic [2**ADDR_BITS-1:0]  busy_vec
);
   localparam int NUM_REGS = 2**ADDR_BITS;

   logic                wr_hit;
   logic [NUM_REGS-1:0] busy_nxt;

   always_comb begin
      wr_hit = 1'b0;
      for (int p = 0; p < NWR; p++)
         if (wr_en[p] && `RF_SLICE(wr_addr, p, ADDR_BITS) == iss_addr)
            wr_hit = 1'b1;
   end

   assign iss_rdy = !busy_vec[iss_addr] || wr_hit;

   always_comb begin
      busy_nxt = busy_vec;
      for (int p = 0; p < NWR; p++)
         if (wr_en[p])
            busy_nxt[`RF_SLICE(wr_addr, p, ADDR_BITS)] = 1'b0;
      if (iss_en && iss_rdy)
         busy_nxt[iss_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         busy_vec <= '0;
         iss_err  <= 1'b0;
      end else begin
         busy_vec <= busy_nxt;
         if (iss_en && !iss_rdy)
            iss_err <= 1'b1;
      end
   end
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional write-to-read bypass, busy
// scoreboard and a captured snapshot of the three accelerator config registers.
module regfile_mp_sb
   import regfile_mp_sb_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int NRD       = 2,
   parameter int NWR       = 2,
   parameter int BYPASS    = 1,
   parameter int CFG_BASE  = CFG_BASE_DEF
) (
   input logic            CLK,
   input logic            RST,
   regfile_mp_sb_if.slave bus
);
   localparam int NUM_REGS = 2**ADDR_BITS;

   logic [DATA_BITS-1:0] regs [NUM_REGS];
   logic [DATA_BITS-1:0] cfg_next [CFG_NUM];
   logic                 cfg_wr_hit;
   logic [NUM_REGS-1:0]  busy_vec;
   logic [ADDR_BITS-1:0] ra;
   logic [DATA_BITS-1:0] rdat;
   logic                 rhit;

   regfile_scoreboard #(.ADDR_BITS(ADDR_BITS), .NWR(NWR)) u_sb (
      .CLK      (CLK),
      .RST      (RST),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .iss_en   (bus.iss_en),
      .iss_addr (bus.iss_addr),
      .iss_rdy  (bus.iss_rdy),
      .iss_err  (bus.iss_err),
      .busy_vec (busy_vec)
   );
   assign bus.busy_vec = busy_vec;

   // Ascending port order lets the higher-index port win a collision.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else begin
         for (int p = 0; p < NWR; p++)
            if (bus.wr_en[p] && `RF_SLICE(bus.wr_addr, p, ADDR_BITS) != '0)
               regs[`RF_SLICE(bus.wr_addr, p, ADDR_BITS)] <= `RF_SLICE(bus.wr_data, p, DATA_BITS);
      end
   end

   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      ra   = '0;
      rdat = '0;
      rhit = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         ra   = `RF_SLICE(bus.rd_addr, k, ADDR_BITS);
         rdat = regs[ra];
         rhit = 1'b0;
         if (BYPASS != 0)
            for (int p = 0; p < NWR; p++)
               if (bus.wr_en[p] && `RF_SLICE(bus.wr_addr, p, ADDR_BITS) == ra) begin
                  rdat = `RF_SLICE(bus.wr_data, p, DATA_BITS);
                  rhit = 1'b1;
               end
         if (ra == '0)
            rdat = '0;
         `RF_SLICE(bus.rd_data, k, DATA_BITS) = rdat;
         bus.rd_busy[k] = busy_vec[ra] && !rhit;
      end
   end

   // Post-write view of the config registers, so a capture includes same-cycle writes.
   always_comb begin
      cfg_wr_hit = 1'b0;
      for (int i = 0; i < CFG_NUM; i++) begin
         cfg_next[i] = regs[ADDR_BITS'(CFG_BASE + i)];
         for (int p = 0; p < NWR; p++)
            if (bus.wr_en[p] && `RF_SLICE(bus.wr_addr, p, ADDR_BITS) == ADDR_BITS'(CFG_BASE + i)
                && `RF_SLICE(bus.wr_addr, p, ADDR_BITS) != '0) begin
               cfg_next[i] = `RF_SLICE(bus.wr_data, p, DATA_BITS);
               cfg_wr_hit  = 1'b1;
            end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         bus.Buffer_Base_Address <= '0;
         bus.Buffer_Load_Amount  <= '0;
         bus.DMEM_Base_Address   <= '0;
         bus.cfg_valid           <= 1'b0;
         bus.cfg_stale           <= 1'b0;
      end else if (bus.cfg_snap) begin
         bus.Buffer_Base_Address <= cfg_next[CFG_OFS_BBA];
         bus.Buffer_Load_Amount  <= cfg_next[CFG_OFS_BLA];
         bus.DMEM_Base_Address   <= cfg_next[CFG_OFS_DMB];
         bus.cfg_valid           <= 1'b1;
         bus.cfg_stale           <= 1'b0;
      end else if (cfg_wr_hit) begin
         bus.cfg_stale <= 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (NRD=2, NWR=2, BYPASS=1).
module tb_regfile_mp_sb;
   logic CLK;
   logic RST;
   int   n_tests;
   int   n_fail;

   regfile_mp_sb_if #(.DATA_BITS(64), .ADDR_BITS(5), .NRD(2), .NWR(2)) bus ();

   regfile_mp_sb #(
      .DATA_BITS(64), .ADDR_BITS(5), .NRD(2), .NWR(2), .BYPASS(1), .CFG_BASE(29)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      bus.wr_en    = '0;
      bus.iss_en   = 1'b0;
      bus.cfg_snap = 1'b0;
   endtask

   task automatic setwr(input int p, input logic [4:0] a, input logic [63:0] d);
      bus.wr_en[p]            = 1'b1;
      bus.wr_addr[p*5 +: 5]   = a;
      bus.wr_data[p*64 +: 64] = d;
   endtask

   task automatic setrd(input int k, input logic [4:0] a);
      bus.rd_addr[k*5 +: 5] = a;
   endtask

   function automatic logic [63:0] rd(input int k);
      return bus.rd_data[k*64 +: 64];
   endfunction

   initial begin
      n_tests = 0;
      n_fail  = 0;
      RST = 1'b1;
      bus.rd_addr  = '0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.iss_addr = '0;
      idle();
      tick();
      tick();
      RST = 1'b0;

      // Reset state
      chk("rst_busy_vec", 64'(bus.busy_vec), 64'h0);
      chk("rst_iss_err",  64'(bus.iss_err), 64'h0);
      chk("rst_valid",    64'(bus.cfg_valid), 64'h0);
      chk("rst_stale",    64'(bus.cfg_stale), 64'h0);
      chk("rst_bba",      bus.Buffer_Base_Address, 64'h0);
      chk("rst_bla",      bus.Buffer_Load_Amount, 64'h0);
      chk("rst_dmb",      bus.DMEM_Base_Address, 64'h0);
      for (int r = 0; r < 32; r++) begin
         setrd(0, 5'(r));
         #1 chk($sformatf("rst_reg%0d", r), rd(0), 64'h0);
      end

      // Basic write then read
      setwr(0, 5'd5, 64'hDEAD);
      tick();
      idle();
      setrd(0, 5'd5);
      #1 chk("wr_x5", rd(0), 64'hDEAD);

      // Bypass of same-cycle write
      setwr(0, 5'd5, 64'hBEEF);
      #1 chk("byp_x5", rd(0), 64'hBEEF);
      tick();
      idle();

      // Collision: port1 wins for both bypass and stored value
      setwr(0, 5'd7, 64'h11);
      setwr(1, 5'd7, 64'h22);
      setrd(1, 5'd7);
      #1 chk("coll_byp", rd(1), 64'h22);
      tick();
      idle();
      #1 chk("coll_store", rd(1), 64'h22);

      // Register 0
      setwr(0, 5'd0, 64'hFFFF);
      bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
      setrd(0, 5'd0);
      #1 chk("x0_byp", rd(0), 64'h0);
      chk("x0_rdy", 64'(bus.iss_rdy), 64'h1);
      tick();
      idle();
      #1 chk("x0_rd", rd(0), 64'h0);
      chk("x0_busy", 64'(bus.busy_vec[0]), 64'h0);
      chk("x0_err", 64'(bus.iss_err), 64'h0);

      // Scoreboard: issue x3
      bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
      #1 chk("iss3_rdy", 64'(bus.iss_rdy), 64'h1);
      tick();
      idle();
      setrd(0, 5'd3);
      #1 chk("iss3_busy", 64'(bus.busy_vec), 64'h8);
      chk("iss3_rd_busy", 64'(bus.rd_busy[0]), 64'h1);

      // Issue x3 again: rejected
      bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
      #1 chk("reiss_rdy", 64'(bus.iss_rdy), 64'h0);
      tick();
      idle();
      #1 chk("reiss_err", 64'(bus.iss_err), 64'h1);
      chk("reiss_busy", 64'(bus.busy_vec), 64'h8);

      // Write + issue same reg: set wins
      setwr(0, 5'd3, 64'h33);
      bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
      #1 chk("wi_rdy", 64'(bus.iss_rdy), 64'h1);
      chk("wi_rd_busy_byp", 64'(bus.rd_busy[0]), 64'h0);
      tick();
      idle();
      #1 chk("wi_busy", 64'(bus.busy_vec), 64'h8);
      chk("wi_data", rd(0), 64'h33);

      // Plain write clears busy
      setwr(1, 5'd3, 64'h44);
      tick();
      idle();
      #1 chk("clr_busy", 64'(bus.busy_vec), 64'h0);
      chk("clr_data", rd(0), 64'h44);
      chk("err_sticky", 64'(bus.iss_err), 64'h1);

      // Snapshot, with x31 written in the capture cycle
      setwr(0, 5'd29, 64'h1000);
      setwr(1, 5'd30, 64'd64);
      tick();
      idle();
      setwr(0, 5'd31, 64'h8000);
      bus.cfg_snap = 1'b1;
      tick();
      idle();
      #1 chk("snap_bba", bus.Buffer_Base_Address, 64'h1000);
      chk("snap_bla", bus.Buffer_Load_Amount, 64'd64);
      chk("snap_dmb", bus.DMEM_Base_Address, 64'h8000);
      chk("snap_valid", 64'(bus.cfg_valid), 64'h1);
      chk("snap_stale0", 64'(bus.cfg_stale), 64'h0);

      setwr(0, 5'd30, 64'd128);
      tick();
      idle();
      #1 chk("stale_set", 64'(bus.cfg_stale), 64'h1);
      chk("stale_bla_hold", bus.Buffer_Load_Amount, 64'd64);
      bus.cfg_snap = 1'b1;
      tick();
      idle();
      #1 chk("resnap_bla", bus.Buffer_Load_Amount, 64'd128);
      chk("resnap_stale", 64'(bus.cfg_stale), 64'h0);

      // Mid-operation reset with write, snap and issue pending
      bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
      tick();
      idle();
      #1 chk("pre_rst_busy", 64'(bus.busy_vec), 64'h8);
      RST = 1'b1;
      setwr(0, 5'd5, 64'h55);
      setwr(1, 5'd29, 64'h77);
      bus.cfg_snap = 1'b1;
      bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
      tick();
      RST = 1'b0;
      idle();
      setrd(0, 5'd5);
      setrd(1, 5'd29);
      #1 chk("mrst_busy", 64'(bus.busy_vec), 64'h0);
      chk("mrst_err", 64'(bus.iss_err), 64'h0);
      chk("mrst_valid", 64'(bus.cfg_valid), 64'h0);
      chk("mrst_stale", 64'(bus.cfg_stale), 64'h0);
      chk("mrst_bba", bus.Buffer_Base_Address, 64'h0);
      chk("mrst_bla", bus.Buffer_Load_Amount, 64'h0);
      chk("mrst_dmb", bus.DMEM_Base_Address, 64'h0);
      chk("mrst_x5", rd(0), 64'h0);
      chk("mrst_x29", rd(1), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
